// File: rtl/freepdk45_sram_1w1r_param.sv
// Purpose : parametrised single-clock 1-write/1-read SRAM model with lane write mask,
//           same-address collision handling (optional write-to-read bypass) and a
//           zero-fill sweep after reset.
// Latency : read data returns READ_LATENCY-1 edges after the sampling edge; writes commit
//           at the sampling edge.
// Backpr. : none per request; both ports are ignored while ready=0 (init sweep / reset).
// Ports   : clk0/rstb clock and async active-low reset;
//           csb0/addr0/wmask0/din0 write port;
//           csb1/addr1 read port;
//           dout1/dout1_valid/collision read results;
//           ready high when requests are accepted.
module freepdk45_sram_1w1r_param #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 6,
  parameter int NUM_WMASKS    = 4,
  parameter int READ_LATENCY  = 1,
  parameter int BYPASS        = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clk0,
  input  logic                  rstb,
  input  logic                  csb0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision,
  output logic                  ready
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int LW        = DATA_WIDTH / NUM_WMASKS;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_we;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  wr_en, rd_en, rd_coll;
  logic [DATA_WIDTH-1:0] rd_old, rd_word;

  // Data presented to the final output register.
  logic                  o_vld_in, o_col_in;
  logic [DATA_WIDTH-1:0] o_dat_in;

  // ---------------------------------------------------------------------------
  // Init / run state machine
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_we    = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (INIT_ON_RESET != 0) begin
          init_we    = 1'b1;
          init_cnt_d = init_cnt_q + 1'b1;
          if (init_cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // ready is registered alongside the state so it equals (state == RUN) without
  // a combinational path from the state decode.
  always_ff @(posedge clk0 or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ready      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready      <= (state_d == ST_RUN);
    end
  end

  // ---------------------------------------------------------------------------
  // Port qualification. ready is cleared asynchronously, so a write at an edge
  // coinciding with reset assertion never reaches the array.
  // ---------------------------------------------------------------------------
  assign wr_en   = ready & ~csb0;
  assign rd_en   = ready & ~csb1;
  assign rd_coll = wr_en & rd_en & (addr0 == addr1);

  // ---------------------------------------------------------------------------
  // Array: only the init sweep ever clears it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk0) begin
    if (init_we) begin
      mem[init_cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) mem[addr0][i*LW +: LW] <= din0[i*LW +: LW];
      end
    end
  end

  // Read sees the pre-write contents; on a collision with bypass enabled the
  // enabled write lanes are forwarded over the old word.
  assign rd_old = mem[addr1];

  always_comb begin
    rd_word = rd_old;
    if ((BYPASS != 0) && rd_coll) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) rd_word[i*LW +: LW] = din0[i*LW +: LW];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional extra pipeline stage for READ_LATENCY=2. Async reset discards any
  // read still in flight.
  // ---------------------------------------------------------------------------
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s_vld, s_col;
      logic [DATA_WIDTH-1:0] s_dat;

      always_ff @(posedge clk0 or negedge rstb) begin
        if (!rstb) begin
          s_vld <= 1'b0;
          s_col <= 1'b0;
          s_dat <= '0;
        end else begin
          s_vld <= rd_en;
          s_col <= rd_coll;
          if (rd_en) s_dat <= rd_word;
        end
      end

      assign o_vld_in = s_vld;
      assign o_col_in = s_col;
      assign o_dat_in = s_dat;
    end else begin : g_lat1
      assign o_vld_in = rd_en;
      assign o_col_in = rd_coll;
      assign o_dat_in = rd_word;
    end
  endgenerate

  // Output register: dout1 holds its value between reads.
  always_ff @(posedge clk0 or negedge rstb) begin
    if (!rstb) begin
      dout1       <= '0;
      dout1_valid <= 1'b0;
      collision   <= 1'b0;
    end else begin
      dout1_valid <= o_vld_in;
      collision   <= o_col_in;
      if (o_vld_in) dout1 <= o_dat_in;
    end
  end

endmodule

// File: tb/tb_freepdk45_sram_1w1r_param.sv
// Directed bench for freepdk45_sram_1w1r_param.
// Three instances share one stimulus stream: "a" (defaults, latency 1, bypass),
// "b" (latency 2, no bypass) and "c" (16 words, no init sweep, ready check only).
module tb_freepdk45_sram_1w1r_param;

  logic        clk0 = 1'b0;
  logic        rstb;
  logic        csb0, csb1;
  logic [5:0]  addr0, addr1;
  logic [3:0]  wmask0;
  logic [31:0] din0;

  logic [31:0] a_dout, b_dout, c_dout;
  logic        a_vld, b_vld, c_vld;
  logic        a_col, b_col, c_col;
  logic        a_rdy, b_rdy, c_rdy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk0 = ~clk0;

  freepdk45_sram_1w1r_param dut_a (
    .clk0(clk0), .rstb(rstb), .csb0(csb0), .addr0(addr0), .wmask0(wmask0), .din0(din0),
    .csb1(csb1), .addr1(addr1), .dout1(a_dout), .dout1_valid(a_vld), .collision(a_col),
    .ready(a_rdy));

  freepdk45_sram_1w1r_param #(.READ_LATENCY(2), .BYPASS(0)) dut_b (
    .clk0(clk0), .rstb(rstb), .csb0(csb0), .addr0(addr0), .wmask0(wmask0), .din0(din0),
    .csb1(csb1), .addr1(addr1), .dout1(b_dout), .dout1_valid(b_vld), .collision(b_col),
    .ready(b_rdy));

  freepdk45_sram_1w1r_param #(.ADDR_WIDTH(4), .INIT_ON_RESET(0)) dut_c (
    .clk0(clk0), .rstb(rstb), .csb0(csb0), .addr0(addr0[3:0]), .wmask0(wmask0), .din0(din0),
    .csb1(csb1), .addr1(addr1[3:0]), .dout1(c_dout), .dout1_valid(c_vld), .collision(c_col),
    .ready(c_rdy));

  // Advance one edge and settle just after it.
  task automatic cyc();
    @(posedge clk0);
    #1;
  endtask

  task automatic idle();
    csb0 = 1'b1; csb1 = 1'b1; addr0 = '0; addr1 = '0; wmask0 = '0; din0 = '0;
  endtask

  // Reset values, then release with both ports requesting during the sweep.
  task automatic test_reset();
    idle();
    rstb = 1'b0;
    #1;
    nvec++; if (a_dout !== 32'h0) begin nerr++; $display("FAIL reset_dout a got %h exp 0", a_dout); end
    nvec++; if (a_vld !== 1'b0) begin nerr++; $display("FAIL reset_vld a got %b exp 0", a_vld); end
    nvec++; if (a_col !== 1'b0) begin nerr++; $display("FAIL reset_col a got %b exp 0", a_col); end
    nvec++; if (a_rdy !== 1'b0) begin nerr++; $display("FAIL reset_rdy a got %b exp 0", a_rdy); end
    nvec++; if (b_rdy !== 1'b0) begin nerr++; $display("FAIL reset_rdy b got %b exp 0", b_rdy); end
    nvec++; if (c_rdy !== 1'b0) begin nerr++; $display("FAIL reset_rdy c got %b exp 0", c_rdy); end
    cyc();
    // Gated requests held through INIT: write all-ones to addr 0, read addr 0.
    csb0 = 1'b0; addr0 = 6'd0; wmask0 = 4'hF; din0 = 32'hFFFF_FFFF;
    csb1 = 1'b0; addr1 = 6'd0;
    rstb = 1'b1;
    for (int e = 1; e <= 64; e++) begin
      cyc();
      nvec++; if (a_rdy !== (e == 64)) begin nerr++; $display("FAIL init_rdy a edge %0d got %b exp %b", e, a_rdy, (e == 64)); end
      nvec++; if (a_vld !== 1'b0) begin nerr++; $display("FAIL init_vld a edge %0d got %b exp 0", e, a_vld); end
      nvec++; if (b_vld !== 1'b0) begin nerr++; $display("FAIL init_vld b edge %0d got %b exp 0", e, b_vld); end
      if (e == 1) begin
        nvec++; if (c_rdy !== 1'b1) begin nerr++; $display("FAIL noinit_rdy c got %b exp 1", c_rdy); end
      end
    end
    idle();
  endtask

  // Every address reads back zero, including addr 0 written during INIT.
  task automatic test_init_reads();
    for (int a = 0; a < 64; a++) begin
      csb1 = 1'b0; addr1 = 6'(a);
      cyc();
      nvec++; if (a_vld !== 1'b1 || a_dout !== 32'h0) begin nerr++; $display("FAIL init_read a addr %0d got vld=%b %h exp vld=1 0", a, a_vld, a_dout); end
      if (a > 0) begin
        nvec++; if (b_vld !== 1'b1 || b_dout !== 32'h0) begin nerr++; $display("FAIL init_read b addr %0d got vld=%b %h exp vld=1 0", a - 1, b_vld, b_dout); end
      end
    end
    idle();
    cyc();
    nvec++; if (a_vld !== 1'b0) begin nerr++; $display("FAIL init_read_end a vld got %b exp 0", a_vld); end
    nvec++; if (b_vld !== 1'b1 || b_dout !== 32'h0) begin nerr++; $display("FAIL init_read b addr 63 got vld=%b %h exp vld=1 0", b_vld, b_dout); end
    cyc();
  endtask

  task automatic test_masked_write();
    csb0 = 1'b0; addr0 = 6'd5; wmask0 = 4'b1111; din0 = 32'hFFFF_FFFF;
    cyc();
    wmask0 = 4'b0101; din0 = 32'h1234_5678;
    cyc();
    idle();
    csb1 = 1'b0; addr1 = 6'd5;
    cyc();
    nvec++; if (a_vld !== 1'b1 || a_dout !== 32'hFF34_FF78) begin nerr++; $display("FAIL mask_read a got vld=%b %h exp vld=1 ff34ff78", a_vld, a_dout); end
    nvec++; if (b_vld !== 1'b0) begin nerr++; $display("FAIL mask_read b early vld got %b exp 0", b_vld); end
    idle();
    cyc();
    nvec++; if (a_vld !== 1'b0) begin nerr++; $display("FAIL mask_pulse a vld got %b exp 0", a_vld); end
    nvec++; if (a_dout !== 32'hFF34_FF78) begin nerr++; $display("FAIL mask_hold a got %h exp ff34ff78", a_dout); end
    nvec++; if (b_vld !== 1'b1 || b_dout !== 32'hFF34_FF78) begin nerr++; $display("FAIL mask_read b got vld=%b %h exp vld=1 ff34ff78", b_vld, b_dout); end
    cyc();
    nvec++; if (b_vld !== 1'b0) begin nerr++; $display("FAIL mask_pulse b vld got %b exp 0", b_vld); end
  endtask

  // Back-to-back writes of addr k = 0x1000+k, then four back-to-back reads.
  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      csb0 = 1'b0; addr0 = 6'(k); wmask0 = 4'hF; din0 = 32'h1000 + k;
      cyc();
    end
    idle();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin csb1 = 1'b0; addr1 = 6'(c); end
      else csb1 = 1'b1;
      cyc();
      if (c < 4) begin
        nvec++; if (a_vld !== 1'b1 || a_dout !== 32'h1000 + c) begin nerr++; $display("FAIL b2b a cycle %0d got vld=%b %h exp vld=1 %h", c, a_vld, a_dout, 32'h1000 + c); end
      end else begin
        nvec++; if (a_vld !== 1'b0) begin nerr++; $display("FAIL b2b a cycle %0d vld got %b exp 0", c, a_vld); end
      end
      if (c >= 1 && c <= 4) begin
        nvec++; if (b_vld !== 1'b1 || b_dout !== 32'h1000 + c - 1) begin nerr++; $display("FAIL b2b b cycle %0d got vld=%b %h exp vld=1 %h", c, b_vld, b_dout, 32'h1000 + c - 1); end
      end else begin
        nvec++; if (b_vld !== 1'b0) begin nerr++; $display("FAIL b2b b cycle %0d vld got %b exp 0", c, b_vld); end
      end
    end
    idle();
  endtask

  task automatic test_collision();
    csb0 = 1'b0; addr0 = 6'd9; wmask0 = 4'hF; din0 = 32'hAAAA_AAAA;
    cyc();
    wmask0 = 4'b0011; din0 = 32'h5555_5555;
    csb1 = 1'b0; addr1 = 6'd9;
    cyc();
    nvec++; if (a_vld !== 1'b1 || a_col !== 1'b1 || a_dout !== 32'hAAAA_5555) begin nerr++; $display("FAIL coll_bypass a got vld=%b col=%b %h exp 1 1 aaaa5555", a_vld, a_col, a_dout); end
    nvec++; if (b_vld !== 1'b0 || b_col !== 1'b0) begin nerr++; $display("FAIL coll_early b got vld=%b col=%b exp 0 0", b_vld, b_col); end
    csb0 = 1'b1;
    cyc();
    nvec++; if (a_vld !== 1'b1 || a_col !== 1'b0 || a_dout !== 32'hAAAA_5555) begin nerr++; $display("FAIL coll_next a got vld=%b col=%b %h exp 1 0 aaaa5555", a_vld, a_col, a_dout); end
    nvec++; if (b_vld !== 1'b1 || b_col !== 1'b1 || b_dout !== 32'hAAAA_AAAA) begin nerr++; $display("FAIL coll_old b got vld=%b col=%b %h exp 1 1 aaaaaaaa", b_vld, b_col, b_dout); end
    idle();
    cyc();
    nvec++; if (a_vld !== 1'b0 || a_col !== 1'b0) begin nerr++; $display("FAIL coll_end a got vld=%b col=%b exp 0 0", a_vld, a_col); end
    nvec++; if (b_vld !== 1'b1 || b_col !== 1'b0 || b_dout !== 32'hAAAA_5555) begin nerr++; $display("FAIL coll_next b got vld=%b col=%b %h exp 1 0 aaaa5555", b_vld, b_col, b_dout); end
    cyc();
  endtask

  // Read in flight on the latency-2 instance when reset hits.
  task automatic test_reset_mid_read();
    csb1 = 1'b0; addr1 = 6'd5;
    cyc();
    idle();
    rstb = 1'b0;
    #1;
    nvec++; if (b_vld !== 1'b0 || b_dout !== 32'h0 || b_col !== 1'b0) begin nerr++; $display("FAIL midrst b got vld=%b col=%b %h exp 0 0 0", b_vld, b_col, b_dout); end
    nvec++; if (b_rdy !== 1'b0 || a_rdy !== 1'b0) begin nerr++; $display("FAIL midrst_rdy got a=%b b=%b exp 0 0", a_rdy, b_rdy); end
    nvec++; if (a_dout !== 32'h0 || a_vld !== 1'b0) begin nerr++; $display("FAIL midrst a got vld=%b %h exp 0 0", a_vld, a_dout); end
    for (int k = 0; k < 2; k++) begin
      cyc();
      nvec++; if (b_vld !== 1'b0) begin nerr++; $display("FAIL midrst_hold b vld got %b exp 0", b_vld); end
    end
    rstb = 1'b1;
    for (int e = 1; e <= 64; e++) begin
      cyc();
      nvec++; if (b_vld !== 1'b0) begin nerr++; $display("FAIL reinit b edge %0d vld got %b exp 0", e, b_vld); end
      nvec++; if (b_rdy !== (e == 64)) begin nerr++; $display("FAIL reinit_rdy b edge %0d got %b exp %b", e, b_rdy, (e == 64)); end
    end
    csb1 = 1'b0; addr1 = 6'd5;
    cyc();
    nvec++; if (a_vld !== 1'b1 || a_dout !== 32'h0) begin nerr++; $display("FAIL reinit_read a got vld=%b %h exp vld=1 0", a_vld, a_dout); end
    idle();
    cyc();
    nvec++; if (b_vld !== 1'b1 || b_dout !== 32'h0) begin nerr++; $display("FAIL reinit_read b got vld=%b %h exp vld=1 0", b_vld, b_dout); end
  endtask

  initial begin
    test_reset();
    test_init_reads();
    test_masked_write();
    test_back_to_back();
    test_collision();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
